// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited in-order requests to
// instruction memory and buffers returned words with their PCs for the decode stage.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        stall_d,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc
);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [15:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] discard;
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] tag_wr;
    logic [15:0]   buf_data [BUF_DEPTH];
    logic [15:0]   buf_pc   [BUF_DEPTH];
    logic [15:0]   tag_pc   [BUF_DEPTH];

    logic          pop;
    logic          push;
    logic          accept;
    logic          rsp_live;
    logic          credit_ok;
    logic [CW:0]   in_use;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop       = if_valid & ~stall_d & ~redirect_valid;
        rsp_live  = imem_rsp_valid & (outstanding != '0);
        push      = rsp_live & ~redirect_valid & (discard == '0);
        in_use    = {1'b0, outstanding} + {1'b0, occupancy} - (CW+1)'(pop);
        credit_ok = ~redirect_valid & (in_use < (CW+1)'(BUF_DEPTH));
        accept    = credit_ok & imem_req_ready;
    end

    // Reset gates only the port; internal state is already held by the async clear.
    assign imem_req_valid = credit_ok & rst_n;
    assign imem_req_addr  = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            occupancy   <= '0;
            discard     <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 16'd1;
            end

            outstanding <= outstanding + CW'(accept) - CW'(rsp_live);

            // Every request still in flight at a redirect is stale, whatever was pending before.
            if (redirect_valid) begin
                discard <= outstanding - CW'(rsp_live);
            end else if (rsp_live && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (accept) begin
                tag_wr <= next_ptr(tag_wr);
            end
            if (rsp_live) begin
                tag_rd <= next_ptr(tag_rd);
            end

            if (redirect_valid) begin
                buf_rd    <= '0;
                buf_wr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) begin
                    buf_wr <= next_ptr(buf_wr);
                end
                if (pop) begin
                    buf_rd <= next_ptr(buf_rd);
                end
                occupancy <= occupancy + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            buf_data[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]   <= tag_pc[tag_rd];
        end
    end

    assign if_valid = (occupancy != '0);
    assign if_instr = if_valid ? buf_data[buf_rd] : '0;
    assign if_pc    = if_valid ? buf_pc[buf_rd]   : '0;

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));

endmodule
